alu_seq: RTL and testbench

- Parametrised sequential ALU, successor to the fixed 8-bit one-hot-select ALU top.
- Registers two WIDTH-bit operands, executes one of seven one-hot operations and holds the result.
- Adds a multi-cycle shift-add multiply, an accumulator mode (operand A taken from the last result), status flags and a valid/busy handshake.
- Exposes current and next FSM state for bench visibility.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 54 +++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: FSM states and select bit positions.
package alu_pkg;

  localparam int STATE_W = 2;
  localparam int OP_W    = 7;
  localparam int IN_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_OFF  = 2'b00,
    S_IDLE = 2'b01,
    S_BUSY = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // out_sel one-hot bit positions
  localparam int OP_ADD = 6;
  localparam int OP_SUB = 5;
  localparam int OP_MUL = 4;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 2;
  localparam int OP_XOR = 1;
  localparam int OP_NOT = 0;

  // in_sel bit positions (clear has highest priority)
  localparam int IN_PERSIST = 2;
  localparam int IN_LOAD    = 1;
  localparam int IN_CLEAR   = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier. The start edge already folds in bit 0 of b, so the
// remaining WIDTH-1 bits take WIDTH-1 more cycles and done is raised in the
// cycle after the last step; the caller registers product on that edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  // Operand capture on start, then one partial-product step per cycle.
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand   <= {{WIDTH{1'b0}}, a} << 1;
      mplier  <= b >> 1;
      cnt     <= CW'(WIDTH - 1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end
    end
  end

  assign done    = running && (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one-hot op select, single-cycle logic/add/sub, multi-cycle
// multiply, accumulate mode, status flags and a valid/busy handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic [IN_W-1:0]    in_sel,
  input  logic               a_sel,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic [OP_W-1:0]    out_sel,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_hi,
  output logic               carry,
  output logic               ovf,
  output logic               zero,
  output logic               err,
  output logic               valid,
  output logic               busy,
  output logic [STATE_W-1:0] curr_state,
  output logic [STATE_W-1:0] next_state
);

  state_t state, nstate;

  logic               cmd_phase, do_clr, do_ld, sel_ok, is_mul, start_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   op_a, res, diff;
  logic [WIDTH:0]     sum;
  logic               res_c, res_o;

  // Commands are only honoured when not computing; clear beats load.
  assign cmd_phase = (state == S_IDLE) || (state == S_DONE);
  assign do_clr    = cmd_phase && in_sel[IN_CLEAR];
  assign do_ld     = cmd_phase && !in_sel[IN_CLEAR] && in_sel[IN_LOAD];
  assign is_mul    = out_sel[OP_MUL];
  assign sel_ok    = $onehot(out_sel) && ((MUL_EN != 0) || !is_mul);
  assign start_mul = on && do_ld && sel_ok && is_mul;

  // Accumulate mode feeds the registered result back as operand A.
  assign op_a = a_sel ? out : num1;
  assign sum  = {1'b0, op_a} + {1'b0, num2};
  assign diff = op_a - num2;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .abort   (!on),
    .start   (start_mul),
    .a       (op_a),
    .b       (num2),
    .done    (mul_done),
    .product (product)
  );

  // Single-cycle result and its carry/overflow flags.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_o = 1'b0;
    if (out_sel[OP_ADD]) begin
      res   = sum[WIDTH-1:0];
      res_c = sum[WIDTH];
      res_o = (op_a[WIDTH-1] == num2[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    end else if (out_sel[OP_SUB]) begin
      res   = diff;
      res_c = op_a < num2;
      res_o = (op_a[WIDTH-1] != num2[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    end else if (out_sel[OP_AND]) begin
      res = op_a & num2;
    end else if (out_sel[OP_OR]) begin
      res = op_a | num2;
    end else if (out_sel[OP_XOR]) begin
      res = op_a ^ num2;
    end else if (out_sel[OP_NOT]) begin
      res = ~op_a;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_OFF;
    else      state <= nstate;
  end

  // Next-state logic; on=0 wins from any state.
  always_comb begin
    nstate = state;
    if (!on) begin
      nstate = S_OFF;
    end else begin
      case (state)
        S_OFF:  nstate = S_IDLE;
        S_IDLE,
        S_DONE: begin
          if (in_sel[IN_CLEAR])     nstate = S_IDLE;
          else if (in_sel[IN_LOAD]) nstate = !sel_ok ? S_IDLE : (is_mul ? S_BUSY : S_DONE);
          else                      nstate = S_IDLE;
        end
        S_BUSY: if (mul_done) nstate = S_DONE;
        default: nstate = S_OFF;
      endcase
    end
  end

  // Result, flag and error registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out    <= '0;
      out_hi <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (!on) begin
      out    <= '0;
      out_hi <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (do_clr) begin
      out    <= '0;
      out_hi <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (do_ld) begin
      if (!sel_ok) begin
        err <= 1'b1;
      end else if (is_mul) begin
        err <= 1'b0;
      end else begin
        out    <= res;
        out_hi <= '0;
        carry  <= res_c;
        ovf    <= res_o;
        zero   <= (res == '0);
        err    <= 1'b0;
      end
    end else if (state == S_BUSY && mul_done) begin
      out    <= product[WIDTH-1:0];
      out_hi <= product[2*WIDTH-1:WIDTH];
      carry  <= 1'b0;
      ovf    <= (product[2*WIDTH-1:WIDTH] != '0);
      zero   <= (product == '0);
    end
  end

  // Handshake and state visibility outputs.
  always_comb begin
    busy       = (state == S_BUSY);
    valid      = (state == S_DONE);
    curr_state = state;
    next_state = nstate;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: loads push expected results, a negedge
// monitor pops and compares whenever valid is seen, including latency.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  localparam logic [6:0] ADD = 7'b1000000;
  localparam logic [6:0] SUB = 7'b0100000;
  localparam logic [6:0] MUL = 7'b0010000;
  localparam logic [6:0] AND = 7'b0001000;
  localparam logic [6:0] XOR = 7'b0000010;
  localparam logic [6:0] NOT = 7'b0000001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         on  = 1'b0;
  logic [2:0]   in_sel = 3'b000;
  logic         a_sel  = 1'b0;
  logic [W-1:0] num1 = '0, num2 = '0;
  logic [6:0]   out_sel = '0;
  logic [W-1:0] out, out_hi;
  logic         carry, ovf, zero, err, valid, busy;
  logic [1:0]   curr_state, next_state;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         c, o, z, e;
    int           lat;
    int           issue;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .a_sel(a_sel),
    .num1(num1), .num2(num2), .out_sel(out_sel), .out(out), .out_hi(out_hi),
    .carry(carry), .ovf(ovf), .zero(zero), .err(err), .valid(valid),
    .busy(busy), .curr_state(curr_state), .next_state(next_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got out=%h with no pending result", out);
      end else begin
        e = q.pop_front();
        if ({out, out_hi, carry, ovf, zero, err} !== {e.out, e.hi, e.c, e.o, e.z, e.e}) begin
          fails++;
          $display("FAIL result: got out=%h hi=%h c=%b o=%b z=%b e=%b expected out=%h hi=%h c=%b o=%b z=%b e=%b",
                   out, out_hi, carry, ovf, zero, err, e.out, e.hi, e.c, e.o, e.z, e.e);
        end
        tests++;
        if (cyc - e.issue != e.lat) begin
          fails++;
          $display("FAIL latency: got %0d expected %0d", cyc - e.issue, e.lat);
        end
      end
    end
  end

  task automatic do_load(input logic [6:0] op, input logic asel, input logic [W-1:0] n1, n2);
    @(negedge clk);
    out_sel = op; a_sel = asel; num1 = n1; num2 = n2; in_sel = 3'b010;
    @(posedge clk); #1;
  endtask

  // lat counts edges after the load edge until the DONE edge
  task automatic expect_res(input logic [W-1:0] o, hi, input logic c, v, z, input int lat);
    exp_t x;
    x.out = o; x.hi = hi; x.c = c; x.o = v; x.z = z; x.e = 1'b0;
    x.lat = lat; x.issue = cyc;
    q.push_back(x);
  endtask

  task automatic settle();
    @(negedge clk);
    in_sel = 3'b000;
    for (int i = 0; i < 40 && curr_state != S_IDLE; i++) @(negedge clk);
    check("settle_idle", curr_state, S_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", curr_state, S_OFF);
    check("rst_outs", {out, out_hi, carry, ovf, zero, err, valid, busy}, '0);
    rst = 1'b1; on = 1'b1;
    @(posedge clk); #1;
    check("off_to_idle", curr_state, S_IDLE);

    do_load(ADD, 1'b0, 8'h57, 8'h1A); expect_res(8'h71, 8'h00, 0, 0, 0, 0); settle();
    do_load(SUB, 1'b0, 8'h57, 8'h1A); expect_res(8'h3D, 8'h00, 0, 0, 0, 0); settle();

    // multiply: busy for WIDTH cycles, valid on the next one
    do_load(MUL, 1'b0, 8'h57, 8'h1A); expect_res(8'hD6, 8'h08, 0, 1, 0, W);
    check("mul_busy", busy, 1'b1);
    settle();

    // wrap and accumulate
    do_load(ADD, 1'b0, 8'hFF, 8'h01); expect_res(8'h00, 8'h00, 1, 0, 1, 0); settle();
    do_load(ADD, 1'b0, 8'h71, 8'h00); expect_res(8'h71, 8'h00, 0, 0, 0, 0); settle();
    do_load(ADD, 1'b1, 8'h33, 8'h0F); expect_res(8'h80, 8'h00, 0, 1, 0, 0); settle();

    // illegal select holds result, flags err, no valid
    do_load(7'b1100000, 1'b0, 8'h01, 8'h02);
    check("ill_err", err, 1'b1);
    check("ill_out", out, 8'h80);
    check("ill_valid", valid, 1'b0);
    check("ill_state", curr_state, S_IDLE);
    do_load(XOR, 1'b0, 8'hF0, 8'h3C); expect_res(8'hCC, 8'h00, 0, 0, 0, 0); settle();
    check("err_cleared", err, 1'b0);

    // clear
    @(negedge clk); in_sel = 3'b011;
    @(posedge clk); #1;
    check("clr_out", {out, carry, ovf, zero, err}, '0);
    check("clr_state", curr_state, S_IDLE);

    do_load(NOT, 1'b0, 8'h5A, 8'h00); expect_res(8'hA5, 8'h00, 0, 0, 0, 0); settle();

    // abort a multiply with on=0 in its third busy cycle
    do_load(MUL, 1'b0, 8'h03, 8'h05);
    @(negedge clk); in_sel = 3'b000;
    @(negedge clk);
    @(negedge clk); on = 1'b0; #1;
    check("abort_busy_before", busy, 1'b1);
    check("abort_next", next_state, S_OFF);
    @(posedge clk); #1;
    check("abort_state", curr_state, S_OFF);
    check("abort_outs", {out, out_hi, carry, ovf, zero, busy}, '0);
    @(negedge clk); on = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", curr_state, S_IDLE);

    // mid-operation reset
    do_load(ADD, 1'b0, 8'h10, 8'h20); expect_res(8'h30, 8'h00, 0, 0, 0, 0); settle();
    do_load(MUL, 1'b0, 8'h0F, 8'h0F);
    @(negedge clk); in_sel = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_state", curr_state, S_OFF);
    check("mrst_outs", {out, out_hi, carry, ovf, zero, err, valid, busy}, '0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_idle", curr_state, S_IDLE);

    // back-to-back loads from DONE
    do_load(AND, 1'b0, 8'hF0, 8'h3C); expect_res(8'h30, 8'h00, 0, 0, 0, 0);
    do_load(AND, 1'b0, 8'hF0, 8'h0F); expect_res(8'h00, 8'h00, 0, 0, 1, 0);
    check("b2b_done", curr_state, S_DONE);
    settle();

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
